// File: rtl/cpu_pkg.sv
// Shared CPU definitions: interrupt FSM encoding and controller defaults.
package cpu_pkg;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] FIRE    = 2'd2;
  localparam logic [1:0] HANDLER = 2'd3;

  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
  localparam int          NUM_HWINT_DEFAULT  = 6;
endpackage

// File: rtl/epc_select.sv
// EPC source select: a delay-slot victim returns to its branch (PC-4), with 32-bit wrap.
module epc_select (
  input  logic [31:0] pc_i,
  input  logic        delay_slot_i,
  output logic [31:0] epc_o
);
  assign epc_o = delay_slot_i ? (pc_i - 32'd4) : pc_i;
endmodule

// File: rtl/interrupt_flush_controller.sv
// Hardware-interrupt entry/exit sequencer: flush pulse, fetch redirect, EPC capture, EXL.
module interrupt_flush_controller
  import cpu_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT,
  parameter int          NUM_HWINT  = NUM_HWINT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_HWINT-1:0] HWInt,
  input  logic [NUM_HWINT-1:0] IM,
  input  logic                 IE,
  input  logic                 ValidE,
  input  logic                 StallE,
  input  logic [31:0]          PCM,
  input  logic                 AtDelaySlotM,
  input  logic                 EXLClearM,
  output logic                 InterruptRequest,
  output logic                 PCRedirect,
  output logic [31:0]          RedirectPC,
  output logic                 EPCWrite,
  output logic [31:0]          EPC,
  output logic                 EXL,
  output logic [NUM_HWINT-1:0] CauseIP
);
  logic [1:0]           state_q, state_d;
  logic [31:0]          epc_q, epc_d;
  logic                 exl_q, exl_d;
  logic [NUM_HWINT-1:0] cause_ip_q;
  logic [31:0]          epc_sel;
  logic                 pend;

  epc_select u_epc_select (
    .pc_i        (PCM),
    .delay_slot_i(AtDelaySlotM),
    .epc_o       (epc_sel)
  );

  assign pend = IE & ~exl_q & (|(cause_ip_q & IM));

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    exl_d   = exl_q;
    case (state_q)
      IDLE:    if (pend) state_d = ARMED;
      // Only fire when E holds a real, advancing instruction so M has a valid victim next cycle.
      ARMED: begin
        if (!pend)                    state_d = IDLE;
        else if (ValidE && !StallE)   state_d = FIRE;
      end
      FIRE: begin
        epc_d   = epc_sel;
        exl_d   = 1'b1;
        state_d = HANDLER;
      end
      HANDLER: begin
        if (EXLClearM) begin
          exl_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      epc_q      <= '0;
      exl_q      <= 1'b0;
      cause_ip_q <= '0;
    end else begin
      state_q    <= state_d;
      epc_q      <= epc_d;
      exl_q      <= exl_d;
      cause_ip_q <= HWInt;
    end
  end

  assign InterruptRequest = (state_q == FIRE);
  assign PCRedirect       = (state_q == FIRE);
  assign EPCWrite         = (state_q == FIRE);
  assign RedirectPC       = HANDLER_PC;
  assign EPC              = epc_q;
  assign EXL              = exl_q;
  assign CauseIP          = cause_ip_q;
endmodule

// File: tb/tb_interrupt_flush_controller.sv
// Scoreboard bench: stimulus queues expected pulses/snapshots, a negedge monitor checks them.
module tb_interrupt_flush_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  HWInt, IM, CauseIP;
  logic        IE, ValidE, StallE, AtDelaySlotM, EXLClearM;
  logic [31:0] PCM, RedirectPC, EPC;
  logic        InterruptRequest, PCRedirect, EPCWrite, EXL;

  interrupt_flush_controller dut (
    .clk(clk), .reset(reset), .HWInt(HWInt), .IM(IM), .IE(IE),
    .ValidE(ValidE), .StallE(StallE), .PCM(PCM), .AtDelaySlotM(AtDelaySlotM),
    .EXLClearM(EXLClearM), .InterruptRequest(InterruptRequest),
    .PCRedirect(PCRedirect), .RedirectPC(RedirectPC), .EPCWrite(EPCWrite),
    .EPC(EPC), .EXL(EXL), .CauseIP(CauseIP)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] epc; logic exl; } pulse_t;
  typedef struct { int cyc; logic ir; logic [31:0] epc; logic exl; logic [5:0] cip; } snap_t;

  pulse_t pq[$];
  snap_t  sq[$];
  int     checks = 0;
  int     errors = 0;
  logic   done = 1'b0;
  logic   fin  = 1'b0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_pulse(input int c, input logic [31:0] epc, input logic exl);
    pulse_t p;
    p.cyc = c; p.epc = epc; p.exl = exl;
    pq.push_back(p);
  endtask

  task automatic exp_snap(input logic ir, input logic [31:0] epc, input logic exl,
                          input logic [5:0] cip);
    snap_t s;
    s.cyc = cyc; s.ir = ir; s.epc = epc; s.exl = exl; s.cip = cip;
    sq.push_back(s);
  endtask

  task automatic eret(input logic [31:0] epc);
    HWInt = '0; EXLClearM = 1'b1;
    tick(1);
    EXLClearM = 1'b0;
    exp_snap(1'b0, epc, 1'b0, 6'd0);
  endtask

  // Monitor
  initial begin
    pulse_t pe;
    snap_t  s;
    logic   epc_pend;
    epc_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (epc_pend) begin
        checks += 2;
        if (EPC !== pe.epc) begin
          errors++; $display("FAIL epc_capture cyc=%0d got=%h exp=%h", cyc, EPC, pe.epc);
        end
        if (EXL !== pe.exl) begin
          errors++; $display("FAIL exl_after_fire cyc=%0d got=%b exp=%b", cyc, EXL, pe.exl);
        end
        epc_pend = 1'b0;
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
        s = sq.pop_front();
        checks++;
        if (s.cyc != cyc) begin
          errors++; $display("FAIL snap_stale cyc=%0d got=%0d exp=%0d", cyc, cyc, s.cyc);
        end else if ({InterruptRequest, PCRedirect, EPCWrite} !== {3{s.ir}} ||
                     EPC !== s.epc || EXL !== s.exl || CauseIP !== s.cip) begin
          errors++;
          $display("FAIL snapshot cyc=%0d got ir/pr/ew=%b%b%b epc=%h exl=%b cip=%b exp ir=%b epc=%h exl=%b cip=%b",
                   cyc, InterruptRequest, PCRedirect, EPCWrite, EPC, EXL, CauseIP,
                   s.ir, s.epc, s.exl, s.cip);
        end
      end
      if (pq.size() > 0 && pq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missed_pulse cyc=%0d got=none exp_cyc=%0d", cyc, pq[0].cyc);
        void'(pq.pop_front());
      end
      if (InterruptRequest === 1'b1) begin
        checks++;
        if (pq.size() > 0 && pq[0].cyc == cyc) begin
          pe = pq.pop_front();
          epc_pend = 1'b1;
          checks++;
          if (PCRedirect !== 1'b1 || EPCWrite !== 1'b1 || RedirectPC !== 32'h0000_4180) begin
            errors++;
            $display("FAIL fire_outputs cyc=%0d got pr=%b ew=%b rpc=%h exp pr=1 ew=1 rpc=00004180",
                     cyc, PCRedirect, EPCWrite, RedirectPC);
          end
        end else begin
          errors++; $display("FAIL unexpected_pulse cyc=%0d got=1 exp=0", cyc);
        end
      end
      if (done && !fin) begin
        fin = 1'b1;
        checks++;
        if (pq.size() != 0 || sq.size() != 0) begin
          errors++;
          $display("FAIL queues_drained got=%0d/%0d exp=0/0", pq.size(), sq.size());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // Stimulus
  initial begin
    reset = 1'b1; HWInt = '0; IM = '0; IE = 1'b0; ValidE = 1'b0; StallE = 1'b0;
    PCM = '0; AtDelaySlotM = 1'b0; EXLClearM = 1'b0;
    tick(2);
    exp_snap(1'b0, 32'h0, 1'b0, 6'd0);
    reset = 1'b0;

    // Basic entry: pulse 3 edges after HWInt rise
    IE = 1'b1; IM = 6'b000001; HWInt = 6'b000001; ValidE = 1'b1; PCM = 32'h0000_3010;
    exp_pulse(cyc + 3, 32'h0000_3010, 1'b1);
    tick(1);
    exp_snap(1'b0, 32'h0, 1'b0, 6'b000001);
    tick(4);
    exp_snap(1'b0, 32'h0000_3010, 1'b1, 6'b000001);
    eret(32'h0000_3010);

    // Delay-slot victim
    HWInt = 6'b000001; PCM = 32'h0000_3024; AtDelaySlotM = 1'b1;
    exp_pulse(cyc + 3, 32'h0000_3020, 1'b1);
    tick(5);
    exp_snap(1'b0, 32'h0000_3020, 1'b1, 6'b000001);
    eret(32'h0000_3020);
    AtDelaySlotM = 1'b0;

    // Masked lines never fire
    IM = 6'd0; HWInt = 6'b111111;
    tick(20);
    exp_snap(1'b0, 32'h0000_3020, 1'b0, 6'b111111);

    // Arm under stall, then retract
    StallE = 1'b1; IM = 6'b111111;
    tick(3);
    HWInt = 6'd0;
    tick(5);
    exp_snap(1'b0, 32'h0000_3020, 1'b0, 6'd0);

    // Stall gating: fire only after StallE falls
    IM = 6'b000001; HWInt = 6'b000001; PCM = 32'h0000_3040;
    tick(7);
    StallE = 1'b0;
    exp_pulse(cyc + 1, 32'h0000_3040, 1'b1);
    tick(3);

    // Nesting: second line held off by EXL, fires 2 edges after eret
    HWInt = 6'b000011; IM = 6'b111111; PCM = 32'h0000_3100;
    tick(5);
    exp_snap(1'b0, 32'h0000_3040, 1'b1, 6'b000011);
    EXLClearM = 1'b1;
    tick(1);
    EXLClearM = 1'b0;
    exp_snap(1'b0, 32'h0000_3040, 1'b0, 6'b000011);
    exp_pulse(cyc + 2, 32'h0000_3100, 1'b1);
    tick(4);
    exp_snap(1'b0, 32'h0000_3100, 1'b1, 6'b000011);
    eret(32'h0000_3100);

    // Reset during FIRE aborts entry
    HWInt = 6'b000001; IM = 6'b000001; PCM = 32'h0000_3200;
    exp_pulse(cyc + 3, 32'h0, 1'b0);
    tick(3);
    reset = 1'b1;
    tick(1);
    exp_snap(1'b0, 32'h0, 1'b0, 6'd0);
    reset = 1'b0;
    // Back in IDLE: full 3-edge latency again; PC 0 in delay slot wraps
    PCM = 32'h0; AtDelaySlotM = 1'b1;
    exp_pulse(cyc + 3, 32'hFFFF_FFFC, 1'b1);
    tick(5);
    exp_snap(1'b0, 32'hFFFF_FFFC, 1'b1, 6'b000001);
    eret(32'hFFFF_FFFC);
    AtDelaySlotM = 1'b0;

    // Bubble in E holds ARMED
    ValidE = 1'b0; HWInt = 6'b000001; PCM = 32'h0000_3300;
    tick(6);
    ValidE = 1'b1;
    exp_pulse(cyc + 1, 32'h0000_3300, 1'b1);
    tick(4);
    eret(32'h0000_3300);

    tick(2);
    done = 1'b1;
    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
